// File: rtl/vga_scan_controller_if.sv
// Source-address and video-output bundle of the VGA scan engine.
// The engine drives the address side and the raster outputs; the render source returns pixel.
interface vga_scan_controller_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] address;
  logic [10:0]       x;
  logic [9:0]        y;
  logic              addr_valid;
  logic [23:0]       pixel;
  logic              hs;
  logic              vs;
  logic              blank_n;
  logic [7:0]        r_data;
  logic [7:0]        g_data;
  logic [7:0]        b_data;
  logic              frame_start;
  logic              line_start;

  modport master (
    output address, x, y, addr_valid,
    input  pixel,
    output hs, vs, blank_n, r_data, g_data, b_data, frame_start, line_start
  );

  modport slave (
    input  address, x, y, addr_valid,
    output pixel,
    input  hs, vs, blank_n, r_data, g_data, b_data, frame_start, line_start
  );
endinterface

// File: rtl/vga_scan_controller.sv
// Parametrised VGA raster engine with programmable porches, sync polarity and 2^S pixel replication.
// Address/coordinates lead RGB, sync, blank and start pulses by exactly PIPE_LAT+1 clocks.
module vga_scan_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int PIPE_LAT    = 2,
  parameter int ADDR_W      = 19
) (
  input logic                   iVGA_CLK,
  input logic                   iRST_n,
  vga_scan_controller_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]     REP_MASK  = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  // Raw-asserted encoding: all-zero is the blank/deasserted state, so reset clears to it.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
    logic ls;
  } stage_t;

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [ADDR_W-1:0] line_base;
  logic              active;
  stage_t            s0_nxt;
  stage_t            s0;
  stage_t            pipe [PIPE_LAT];
  stage_t            tail;

  always_comb begin
    active    = (h < H_ACT) && (v < V_ACT);
    s0_nxt.hs = (h >= HS_BEG) && (h < HS_END);
    s0_nxt.vs = (v >= VS_BEG) && (v < VS_END);
    s0_nxt.act = active;
    s0_nxt.fs = (h == '0) && (v == '0);
    s0_nxt.ls = (h == '0) && (v < V_ACT);
  end

  // line_base replaces the y*width multiply: it steps once per 2^S active lines.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h         <= '0;
      v         <= '0;
      line_base <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v         <= '0;
        line_base <= '0;
      end else begin
        v <= v + VW'(1);
        if ((v < V_ACT) && ((v & REP_MASK) == REP_MASK))
          line_base <= line_base + LINE_STEP;
      end
    end else begin
      h <= h + HW'(1);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bus.address    <= '0;
      bus.x          <= '0;
      bus.y          <= '0;
      bus.addr_valid <= 1'b0;
      s0             <= '0;
    end else begin
      s0             <= s0_nxt;
      bus.addr_valid <= active;
      if (active) begin
        bus.address <= line_base + ADDR_W'(h >> SCALE_SHIFT);
        bus.x       <= 11'(h >> SCALE_SHIFT);
        bus.y       <= 10'(v >> SCALE_SHIFT);
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= s0;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[PIPE_LAT-1];

  // Start pulses ride the delay pipe so they mark the pixel actually on screen.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bus.hs          <= ~HS_POL;
      bus.vs          <= ~VS_POL;
      bus.blank_n     <= 1'b0;
      bus.r_data      <= '0;
      bus.g_data      <= '0;
      bus.b_data      <= '0;
      bus.frame_start <= 1'b0;
      bus.line_start  <= 1'b0;
    end else begin
      bus.hs          <= tail.hs ? HS_POL : ~HS_POL;
      bus.vs          <= tail.vs ? VS_POL : ~VS_POL;
      bus.blank_n     <= tail.act;
      {bus.r_data, bus.g_data, bus.b_data} <= tail.act ? bus.pixel : 24'h0;
      bus.frame_start <= tail.fs;
      bus.line_start  <= tail.ls;
    end
  end
endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: four raster configurations checked every cycle against a
// position-based model, plus hand-computed spot values, counted windows and a mid-frame reset.
module tb_vga_scan_controller;
  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int s;  int lat; int hpol; int vpol; int aw;
  } cfg_t;

  localparam int NDUT = 4;
  localparam cfg_t CFGS [NDUT] = '{
    '{16, 2, 3, 3,    8, 1, 2, 1,   0, 3, 0, 0, 7},
    '{16, 2, 3, 3,    8, 1, 2, 1,   1, 2, 1, 1, 5},
    '{16, 2, 3, 3,    8, 1, 2, 1,   2, 8, 1, 0, 4},
    '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2, 0, 0, 19}
  };

  logic clk;
  logic rst_n;
  logic run;
  int   m;
  int   cmp_cnt;
  int   err_cnt;

  logic [40:0] st0_act [NDUT];
  logic [28:0] out_act [NDUT];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam cfg_t C = CFGS[g];
    vga_scan_controller_if #(.ADDR_W(C.aw)) bus ();
    vga_scan_controller #(
      .H_ACTIVE(C.ha), .H_FP(C.hfp), .H_SYNC(C.hs), .H_BP(C.hbp),
      .V_ACTIVE(C.va), .V_FP(C.vfp), .V_SYNC(C.vs), .V_BP(C.vbp),
      .HS_POL(1'(C.hpol)), .VS_POL(1'(C.vpol)),
      .SCALE_SHIFT(C.s), .PIPE_LAT(C.lat), .ADDR_W(C.aw)
    ) dut (
      .iVGA_CLK(clk),
      .iRST_n(rst_n),
      .bus(bus)
    );

    // Render source: returns {5'b0, address} exactly PIPE_LAT clocks after the address.
    logic [23:0] src [8];
    always @(posedge clk) begin
      src[0] <= {5'b0, 19'(bus.address)};
      for (int i = 1; i < 8; i++) src[i] <= src[i-1];
    end
    assign bus.pixel = src[C.lat-1];

    assign st0_act[g] = {19'(bus.address), bus.x, bus.y, bus.addr_valid};
    assign out_act[g] = {bus.hs, bus.vs, bus.blank_n, bus.r_data, bus.g_data, bus.b_data,
                         bus.frame_start, bus.line_start};
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 0;
    else        m <= m + 1;
  end

  // Address-side expectation after the m-th edge since reset release: pixel n = m-1 of the scan.
  function automatic logic [40:0] exp_st0(input cfg_t c, input int mm);
    int ht, vt, n, h, v, hh, vv, addr;
    if (mm < 1) return '0;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    n  = (mm - 1) % (ht * vt);
    h  = n % ht;
    v  = n / ht;
    if (v >= c.va)      begin hh = c.ha - 1; vv = c.va - 1; end
    else if (h >= c.ha) begin hh = c.ha - 1; vv = v;        end
    else                begin hh = h;        vv = v;        end
    addr = (vv >> c.s) * (c.ha >> c.s) + (hh >> c.s);
    return {19'(addr), 11'(hh >> c.s), 10'(vv >> c.s), (h < c.ha) && (v < c.va)};
  endfunction

  // Raster-side expectation: the pixel shown lags its address by lat+1 clocks.
  function automatic logic [28:0] exp_out(input cfg_t c, input int mm);
    int ht, vt, n, h, v, addr;
    logic act, hsync, vsync, hp, vp;
    logic [23:0] rgb;
    hp = c.hpol[0];
    vp = c.vpol[0];
    n  = mm - c.lat - 2;
    if (n < 0) return {~hp, ~vp, 27'b0};
    ht    = c.ha + c.hfp + c.hs + c.hbp;
    vt    = c.va + c.vfp + c.vs + c.vbp;
    n     = n % (ht * vt);
    h     = n % ht;
    v     = n / ht;
    act   = (h < c.ha) && (v < c.va);
    hsync = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
    vsync = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
    addr  = (v >> c.s) * (c.ha >> c.s) + (h >> c.s);
    rgb   = act ? {5'b0, 19'(addr)} : 24'h0;
    return {hsync ? hp : ~hp, vsync ? vp : ~vp, act, rgb, (h == 0) && (v == 0),
            (h == 0) && (v < c.va)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_m(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m != target && guard < 6000);
    if (m != target) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL wait_m: m=%0d required %0d", m, target);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("stage0 dut%0d m=%0d", g, m), 64'(st0_act[g]), 64'(exp_st0(CFGS[g], m)));
        check($sformatf("raster dut%0d m=%0d", g, m), 64'(out_act[g]), 64'(exp_out(CFGS[g], m)));
      end
    end
  end

  initial begin
    int hs_low, blank_hi, hs_hi;
    cmp_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    run     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset raster dut0", 64'(out_act[0]), 64'h1800_0000);
    check("reset raster dut1", 64'(out_act[1]), 64'h0);
    check("reset stage0 dut3", 64'(st0_act[3]), 64'h0);
    #1 rst_n = 1'b1;

    wait_m(5);
    check("first frame_start dut0", 64'(out_act[0][1]), 64'h1);
    check("first blank_n dut0", 64'(out_act[0][26]), 64'h1);
    wait_m(17);
    check("hold addr dut0", 64'(st0_act[0][40:22]), 64'd15);
    check("hold valid dut0", 64'(st0_act[0][0]), 64'h0);
    wait_m(49);
    check("line2 base dut1", 64'(st0_act[1][40:22]), 64'd8);
    wait_m(78);
    check("addr (5,3) dut1", 64'(st0_act[1][40:22]), 64'd10);
    wait_m(136);
    check("rgb (6,5) dut2", 64'(out_act[2][25:2]), 64'd5);
    wait_m(184);
    check("max addr dut0", 64'(st0_act[0][40:22]), 64'd127);
    check("max addr dut1", 64'(st0_act[1][40:22]), 64'd31);
    wait_m(293);
    check("second frame_start dut0", 64'(out_act[0][1]), 64'h1);

    wait_m(803);
    hs_low = 0; blank_hi = 0; hs_hi = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (out_act[3][28] == 1'b0) hs_low++;
      if (out_act[3][26] == 1'b1) blank_hi++;
      if (i < 24 && out_act[1][28] == 1'b1) hs_hi++;
    end
    check("hs low clocks per line dut3", 64'(hs_low), 64'd96);
    check("blank_n high clocks per line dut3", 64'(blank_hi), 64'd640);
    check("hs high clocks per line dut1", 64'(hs_hi), 64'd3);

    wait_m(2000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset raster dut0", 64'(out_act[0]), 64'h1800_0000);
    check("async reset raster dut1", 64'(out_act[1]), 64'h0);
    check("async reset stage0 dut0", 64'(st0_act[0]), 64'h0);
    check("async reset raster dut3", 64'(out_act[3]), 64'h1800_0000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    wait_m(1);
    check("restart addr valid dut0", 64'(st0_act[0][0]), 64'h1);
    wait_m(5);
    check("restart frame_start dut0", 64'(out_act[0][1]), 64'h1);
    wait_m(800);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
